gpr_file_mp: RTL and testbench

//  Parametrised multi-port general-purpose register file with a built-in busy scoreboard.

---
 rtl/gpr_pkg.sv | 35 +++
 rtl/gpr_scoreboard.sv | 38 +++
 rtl/gpr_file_mp.sv | 114 +++++++++++
 tb/tb_gpr_file_mp.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared constants, defaults and write-port arbitration for the GPR file and its hazard unit.
package gpr_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    // Arbitration operands are zero-padded to these bounds so one function serves any port count.
    localparam int MAX_WR     = 8;
    localparam int MAX_ADDR_W = 8;
    localparam int WR_IDX_W   = 3;

    typedef struct packed {
        logic                hit;
        logic [WR_IDX_W-1:0] idx;
    } wr_hit_t;

    // The highest-index enabled port whose address matches wins.
    function automatic wr_hit_t winning_wr(
        input logic [MAX_ADDR_W-1:0]        addr,
        input logic [MAX_WR-1:0]            we,
        input logic [MAX_WR*MAX_ADDR_W-1:0] wa
    );
        wr_hit_t r;
        r = '0;
        for (int j = 0; j < MAX_WR; j++) begin
            if (we[j] && (wa[j*MAX_ADDR_W +: MAX_ADDR_W] == addr)) begin
                r.hit = 1'b1;
                r.idx = WR_IDX_W'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Busy-bit scoreboard: one "producer in flight" bit per register.
// Priority on an edge: reset, then flush (clears all), then issue-set over write-clear.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    localparam int DEPTH   = 1 << ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    input  logic [NUM_WR-1:0]        clr,
    input  logic [NUM_WR*ADDR_W-1:0] wa,
    output logic [DEPTH-1:0]         busy
);

    logic [DEPTH-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NUM_WR; j++) begin
            if (clr[j]) busy_nxt[wa[j*ADDR_W +: ADDR_W]] = 1'b0;
        end
        if (iss_valid && !((ZERO_REG != 0) && (iss_addr == ADDR_W'(REG_ZERO))))
            busy_nxt[iss_addr] = 1'b1;
        if (flush) busy_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) busy <= '0;
        else          busy <= busy_nxt;
    end

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port register file with write->read bypass, busy scoreboard and saturating write counter.
// Reads are combinational (latency 0); writes commit on posedge; no backpressure.
module gpr_file_mp
    import gpr_pkg::*;
#(
    parameter int          DATA_W       = DATA_W_DEF,
    parameter int          ADDR_W       = ADDR_W_DEF,
    parameter int          NUM_RD       = 3,
    parameter int          NUM_WR       = 2,
    parameter int          BYPASS       = 1,
    parameter int          ZERO_REG     = 1,
    parameter logic [31:0] WR_COUNT_RST = 32'h0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] wa,
    input  logic [NUM_WR*DATA_W-1:0] wd,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic [31:0]              wr_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(NUM_WR + 1);

    logic [DATA_W-1:0]              regs [DEPTH];
    logic [DEPTH-1:0]               busy;
    logic [NUM_WR-1:0]              wr_eff;
    logic [MAX_WR-1:0]              we_pad;
    logic [MAX_WR*MAX_ADDR_W-1:0]   wa_pad;
    logic [CNT_W-1:0]               wr_inc;
    logic [32:0]                    cnt_sum;

    // A write is committed only out of reset and when not aimed at the hardwired zero register.
    always_comb begin
        we_pad = '0;
        wa_pad = '0;
        wr_inc = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            wr_eff[j] = we[j] && reset_n &&
                        !((ZERO_REG != 0) && (wa[j*ADDR_W +: ADDR_W] == ADDR_W'(REG_ZERO)));
            we_pad[j] = wr_eff[j];
            wa_pad[j*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(wa[j*ADDR_W +: ADDR_W]);
            wr_inc = wr_inc + CNT_W'(wr_eff[j]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_eff[j]) regs[wa[j*ADDR_W +: ADDR_W]] <= wd[j*DATA_W +: DATA_W];
            end
        end
    end

    gpr_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .reset_n   (reset_n),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .flush     (flush),
        .clr       (wr_eff),
        .wa        (wa),
        .busy      (busy)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] d;
        logic              b;
        logic              rz;
        wr_hit_t           h;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];
        assign rz = (ZERO_REG != 0) && (ra == ADDR_W'(REG_ZERO));
        assign h  = winning_wr(MAX_ADDR_W'(ra), we_pad, wa_pad);

        always_comb begin
            d = regs[ra];
            b = reset_n && busy[ra];
            if (rz) begin
                d = '0;
                b = 1'b0;
            end else if ((BYPASS != 0) && h.hit) begin
                d = wd[int'(h.idx)*DATA_W +: DATA_W];
                b = 1'b0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = d;
        assign rd_busy[k]                  = b;
    end

    // The increment is at most NUM_WR, so a carry out of bit 31 means saturate.
    assign cnt_sum = {1'b0, wr_count} + 33'(wr_inc);

    always_ff @(posedge clk) begin
        if (!reset_n)        wr_count <= WR_COUNT_RST;
        else if (cnt_sum[32]) wr_count <= 32'hFFFF_FFFF;
        else                 wr_count <= cnt_sum[31:0];
    end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Directed bench: a bypassing file plus a non-bypassing file with a near-saturated counter reset value.
`timescale 1ns/1ps
module tb_gpr_file_mp;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [14:0] rd_addr;
    logic [95:0] rd_data_b, rd_data_n;
    logic [2:0]  rd_busy_b, rd_busy_n;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        flush;
    logic [31:0] wr_count_b, wr_count_n;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gpr_file_mp u_dut (
        .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush),
        .wr_count(wr_count_b)
    );

    gpr_file_mp #(.BYPASS(0), .WR_COUNT_RST(32'hFFFF_FFFE)) u_nb (
        .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush),
        .wr_count(wr_count_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int k, input logic [4:0] a);
        rd_addr[k*5 +: 5] = a;
    endtask

    task automatic set_wr(input int j, input logic [4:0] a, input logic [31:0] d);
        we[j]            = 1'b1;
        wa[j*5 +: 5]     = a;
        wd[j*32 +: 32]   = d;
    endtask

    initial begin
        // Reset edge with writes and an issue pending: none may take effect.
        reset_n = 1'b0; flush = 1'b0; iss_valid = 1'b1; iss_addr = 5'd6;
        we = '0; wa = '0; wd = '0; rd_addr = '0;
        set_wr(0, 5'd8, 32'hAAAA_0008);
        set_wr(1, 5'd9, 32'hAAAA_0009);
        set_rd(0, 5'd8); set_rd(1, 5'd9); set_rd(2, 5'd6);
        tick();
        chk("rst_rd0_nobypass", rd_data_b[31:0], 32'h0);
        chk("rst_busy_b", {29'b0, rd_busy_b}, 32'h0);
        chk("rst_busy_n", {29'b0, rd_busy_n}, 32'h0);
        chk("rst_cnt_b", wr_count_b, 32'h0);
        chk("rst_cnt_n", wr_count_n, 32'hFFFF_FFFE);
        reset_n = 1'b1; we = '0; iss_valid = 1'b0;
        #1;
        chk("rst_r8", rd_data_b[31:0], 32'h0);
        chk("rst_r9", rd_data_b[63:32], 32'h0);
        chk("rst_busy6", {31'b0, rd_busy_n[2]}, 32'h0);

        // Same-cycle bypass of a write on port 0.
        set_wr(0, 5'd5, 32'hDEAD_BEEF); set_rd(0, 5'd5);
        #1;
        chk("byp_rd0", rd_data_b[31:0], 32'hDEAD_BEEF);
        chk("nobyp_rd0", rd_data_n[31:0], 32'h0);
        tick(); we = '0; #1;
        chk("wr_r5_b", rd_data_b[31:0], 32'hDEAD_BEEF);
        chk("wr_r5_n", rd_data_n[31:0], 32'hDEAD_BEEF);
        chk("cnt_1", wr_count_b, 32'd1);

        // Both ports write r7: port 1 wins, counts as two.
        set_wr(0, 5'd7, 32'h0000_1111); set_wr(1, 5'd7, 32'h0000_2222); set_rd(1, 5'd7);
        #1;
        chk("byp_conflict", rd_data_b[63:32], 32'h0000_2222);
        tick(); we = '0; #1;
        chk("conflict_b", rd_data_b[63:32], 32'h0000_2222);
        chk("conflict_n", rd_data_n[63:32], 32'h0000_2222);
        chk("cnt_3", wr_count_b, 32'd3);

        // Zero register: writes discarded, never busy.
        set_wr(0, 5'd0, 32'hFFFF_FFFF); set_rd(2, 5'd0);
        #1;
        chk("r0_nobyp", rd_data_b[95:64], 32'h0);
        tick(); we = '0; iss_valid = 1'b1; iss_addr = 5'd0;
        tick(); iss_valid = 1'b0; #1;
        chk("r0_data", rd_data_n[95:64], 32'h0);
        chk("r0_busy", {31'b0, rd_busy_n[2]}, 32'h0);
        chk("cnt_r0", wr_count_b, 32'd3);

        // Scoreboard: issue r3, then issue + write r3 on one edge (set wins).
        iss_valid = 1'b1; iss_addr = 5'd3; set_rd(0, 5'd3);
        tick(); iss_valid = 1'b0; #1;
        chk("busy3_b", {31'b0, rd_busy_b[0]}, 32'd1);
        chk("busy3_n", {31'b0, rd_busy_n[0]}, 32'd1);
        iss_valid = 1'b1; set_wr(0, 5'd3, 32'h0000_0033);
        #1;
        chk("busy3_byp", {31'b0, rd_busy_b[0]}, 32'd0);
        chk("data3_byp", rd_data_b[31:0], 32'h0000_0033);
        chk("busy3_nobyp", {31'b0, rd_busy_n[0]}, 32'd1);
        tick(); iss_valid = 1'b0; we = '0; #1;
        chk("set_wins", {31'b0, rd_busy_b[0]}, 32'd1);
        chk("cnt_4", wr_count_b, 32'd4);
        set_wr(1, 5'd3, 32'h0000_0044);
        tick(); we = '0; #1;
        chk("clr3_b", {31'b0, rd_busy_b[0]}, 32'd0);
        chk("clr3_n", {31'b0, rd_busy_n[0]}, 32'd0);
        chk("data3", rd_data_n[31:0], 32'h0000_0044);

        // Flush clears everything and beats a same-cycle issue; the write still commits.
        iss_valid = 1'b1; iss_addr = 5'd3; tick();
        iss_addr = 5'd5; set_rd(1, 5'd5); tick(); iss_valid = 1'b0; #1;
        chk("busy5_pre", {31'b0, rd_busy_n[1]}, 32'd1);
        chk("busy3_pre", {31'b0, rd_busy_n[0]}, 32'd1);
        flush = 1'b1; iss_valid = 1'b1; iss_addr = 5'd4; set_rd(2, 5'd4);
        set_wr(0, 5'd9, 32'h0000_0099);
        tick(); flush = 1'b0; iss_valid = 1'b0; we = '0; #1;
        chk("flush_busy", {29'b0, rd_busy_n}, 32'h0);
        set_rd(2, 5'd9); #1;
        chk("flush_wr", rd_data_n[95:64], 32'h0000_0099);
        chk("cnt_6", wr_count_b, 32'd6);

        // Second reset, then saturation from FFFF_FFFE on the non-bypass file.
        reset_n = 1'b0; tick(); reset_n = 1'b1; #1;
        chk("rst2_cnt_b", wr_count_b, 32'h0);
        chk("rst2_cnt_n", wr_count_n, 32'hFFFF_FFFE);
        chk("rst2_r3", rd_data_b[31:0], 32'h0);
        set_wr(0, 5'd10, 32'h1); set_wr(1, 5'd11, 32'h2);
        tick(); #1;
        chk("sat_1", wr_count_n, 32'hFFFF_FFFF);
        chk("cnt_2b", wr_count_b, 32'd2);
        tick(); we = '0; #1;
        chk("sat_hold", wr_count_n, 32'hFFFF_FFFF);
        chk("cnt_4b", wr_count_b, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
